button_debounce_reader: RTL
===========================

Name: button_debounce_reader

Overview:
- Input-side counterpart to the LED output path: reads the board's mechanical push-buttons and produces clean, clk30-synchronous button events for the rest of the design.
- Each button has its own path:
  - a 2-flop synchroniser,
  - a debounce state machine,
  - a hold-time counter.
- Outputs per button:
  - a debounced level,
  - single-cycle press, release and long-press pulses.

Parameters:
- N_BTN, 2, number of independent buttons.
- DEBOUNCE_CYCLES, 300000, consecutive stable samples needed to accept a change (10 ms at 30 MHz). Must be ≥ 1.
- LONG_CYCLES, 30000000, cycles held after an accepted press before btn_long fires (1 s at 30 MHz). Must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, pad polarity. 1 means the pad reads 0 when pressed.

Ports:
- clk30, input, 1, system clock (30 MHz).
- rst, input, 1, asynchronous active-high reset.
- btn_pad, input, N_BTN, raw asynchronous button pins.
- btn_level, output, N_BTN, debounced pressed state (1 = pressed).
- btn_press, output, N_BTN, 1-cycle pulse on an accepted press.
- btn_release, output, N_BTN, 1-cycle pulse on an accepted release.
- btn_long, output, N_BTN, 1-cycle pulse when hold time reaches LONG_CYCLES.
- btn_was_long, output, N_BTN, level; valid in the btn_release cycle; 1 if that press reached long.

Behaviour:
- Reset: rst is asynchronous, active-high, single clock domain clk30.
  - Synchroniser flops reset to the inactive pad level (1 when ACTIVE_LOW=1).
  - All state machines go to IDLE; all counters go to 0.
  - All outputs go to 0.
  - Reset mid-operation aborts silently: no release pulse is emitted.
- Synchroniser and normalisation:
  - s = synchronised pad, XOR ACTIVE_LOW; s=1 means pressed.
  - Delay from pad to s is 2 clk30 edges.
- Per-button FSM (states: IDLE, DEB_PRESS, HELD, LONG, DEB_REL):
  - IDLE:
    - s=1 → DEB_PRESS with dcnt=1.
  - DEB_PRESS:
    - s=0 → IDLE, nothing emitted.
    - s=1 and dcnt==DEBOUNCE_CYCLES → HELD. btn_press=1 for one cycle; btn_level=1 from the same edge; hcnt=0.
    - Otherwise dcnt++.
  - HELD:
    - hcnt increments every cycle while in HELD, and also while in DEB_REL entered from HELD.
    - hcnt==LONG_CYCLES-1 → LONG. btn_long=1 for one cycle; long_flag=1.
    - s=0 → DEB_REL with dcnt=1.
  - LONG:
    - hcnt stops.
    - s=0 → DEB_REL with dcnt=1.
  - DEB_REL:
    - s=1 → return to HELD or LONG according to long_flag. dcnt cleared; btn_level stays 1; nothing emitted.
    - s=0 and dcnt==DEBOUNCE_CYCLES → IDLE. btn_release=1 for one cycle; btn_was_long=long_flag in that cycle; btn_level=0 from the same edge; long_flag=0.
    - Otherwise dcnt++.
- Latency:
  - Clean press: btn_press rises DEBOUNCE_CYCLES+2 edges after the first edge that samples the pad active.
  - Clean release: same latency for btn_release.
- Boundary conditions:
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
  - If hcnt reaches LONG_CYCLES-1 while in DEB_REL, the LONG transition is deferred. btn_long then fires on return to HELD, or never if the release is accepted.
  - btn_press and btn_release for the same button are never high in the same cycle.
  - btn_long is never high in the same cycle as btn_release.
  - Buttons are fully independent; simultaneous events on different bits are all reported.
- Counter widths:
  - dcnt is $clog2(DEBOUNCE_CYCLES+1) bits.
  - hcnt is $clog2(LONG_CYCLES) bits.
  - Neither counter ever wraps.
- btn_was_long is 0 outside btn_release cycles.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, N_BTN=2):
- Reset, then pad[0] driven 1→0 and held 50 cycles → btn_press[0] pulses exactly 6 edges after the first active sample; btn_level[0]=1; btn_long[0] pulses once 19 cycles after btn_press; no other pulses.
- pad[0] bounces low 3 cycles, high 1, low 2, high → no btn_press, btn_level stays 0.
- Pressed 10 cycles then released cleanly → btn_release[0] pulses 6 edges after the first inactive sample, with btn_was_long=0. The same check after a 40-cycle hold gives btn_was_long=1.
- While HELD, a 3-cycle release glitch → no btn_release, btn_level stays 1, FSM resumes HELD.
- Both pads pressed on the same edge → btn_press[1:0]=2'b11 in one cycle, with independent release timing.
- rst asserted asynchronously mid-hold (between clock edges) → all outputs go to 0 immediately, no btn_release. After rst drops with the pad still low, a fresh btn_press arrives 6 edges later.

Source files
------------

// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_if
//  Description : Pad inputs and clean per-button event outputs of the
//                push-button reader, bundled for connection to consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_debounce_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_pad;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [N_BTN-1:0] btn_was_long;

    // Reader side: samples the pads, sources the events
    modport master (
        input  btn_pad,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output btn_was_long
    );

    // Board/consumer side: drives the pads, receives the events
    modport slave (
        output btn_pad,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  btn_was_long
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce_reader.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_reader
//  Description : Per-button 2-flop synchroniser, debounce FSM and hold-time
//                counter producing a debounced level plus press, release and
//                long-press pulses, all synchronous to clk30.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_reader #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 300000,
    parameter int LONG_CYCLES     = 30000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input wire              clk30,
    input wire              rst,
    button_debounce_if.master bus
);

    localparam int c_DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HW = $clog2(LONG_CYCLES);

    localparam logic [c_DW-1:0] c_DEB_MAX  = c_DW'(DEBOUNCE_CYCLES);
    localparam logic [c_HW-1:0] c_HOLD_MAX = c_HW'(LONG_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DONE     = c_DW'(1);
    localparam logic [c_HW-1:0] c_HONE     = c_HW'(1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_DEB_PRESS = 3'd1;
    localparam logic [2:0] c_S_HELD      = 3'd2;
    localparam logic [2:0] c_S_LONG      = 3'd3;
    localparam logic [2:0] c_S_DEB_REL   = 3'd4;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_s;

    // Two-flop synchroniser; idles at the released pad level
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            r_sync1 <= {N_BTN{ACTIVE_LOW}};
            r_sync2 <= {N_BTN{ACTIVE_LOW}};
        end else begin
            r_sync1 <= bus.btn_pad;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise so that 1 always means pressed
    assign w_s = r_sync2 ^ {N_BTN{ACTIVE_LOW}};

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [2:0]      r_state;
        logic [c_DW-1:0] r_dcnt;
        logic [c_HW-1:0] r_hcnt;
        logic            r_long_flag;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            r_long;
        logic            r_was_long;
        logic [c_HW-1:0] w_hcnt_inc;
        logic            w_hold_hit;

        // Hold counter saturates at the long threshold, so a threshold
        // crossed during a release bounce is remembered until return to HELD
        assign w_hcnt_inc = (r_hcnt == c_HOLD_MAX) ? r_hcnt : r_hcnt + c_HONE;
        assign w_hold_hit = (w_hcnt_inc == c_HOLD_MAX);

        // Debounce / hold state machine with registered event outputs
        always_ff @(posedge clk30 or posedge rst) begin
            if (rst) begin
                r_state     <= c_S_IDLE;
                r_dcnt      <= '0;
                r_hcnt      <= '0;
                r_long_flag <= 1'b0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
                r_was_long  <= 1'b0;
            end else begin
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_long     <= 1'b0;
                r_was_long <= 1'b0;
                case (r_state)
                    c_S_IDLE: begin
                        if (w_s[g]) begin
                            r_state <= c_S_DEB_PRESS;
                            r_dcnt  <= c_DONE;
                        end
                    end
                    c_S_DEB_PRESS: begin
                        if (!w_s[g]) begin
                            r_state <= c_S_IDLE;
                            r_dcnt  <= '0;
                        end else if (r_dcnt == c_DEB_MAX) begin
                            r_state <= c_S_HELD;
                            r_press <= 1'b1;
                            r_level <= 1'b1;
                            r_hcnt  <= '0;
                            r_dcnt  <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + c_DONE;
                        end
                    end
                    c_S_HELD: begin
                        r_hcnt <= w_hcnt_inc;
                        if (w_hold_hit) begin
                            r_state     <= c_S_LONG;
                            r_long      <= 1'b1;
                            r_long_flag <= 1'b1;
                        end else if (!w_s[g]) begin
                            r_state <= c_S_DEB_REL;
                            r_dcnt  <= c_DONE;
                        end
                    end
                    c_S_LONG: begin
                        if (!w_s[g]) begin
                            r_state <= c_S_DEB_REL;
                            r_dcnt  <= c_DONE;
                        end
                    end
                    c_S_DEB_REL: begin
                        // Hold time keeps running only for a press not yet long
                        if (!r_long_flag) begin
                            r_hcnt <= w_hcnt_inc;
                        end
                        if (w_s[g]) begin
                            r_dcnt <= '0;
                            if (r_long_flag) begin
                                r_state <= c_S_LONG;
                            end else if (w_hold_hit) begin
                                // Deferred long-press fires on the way back
                                r_state     <= c_S_LONG;
                                r_long      <= 1'b1;
                                r_long_flag <= 1'b1;
                            end else begin
                                r_state <= c_S_HELD;
                            end
                        end else if (r_dcnt == c_DEB_MAX) begin
                            r_state     <= c_S_IDLE;
                            r_release   <= 1'b1;
                            r_was_long  <= r_long_flag;
                            r_level     <= 1'b0;
                            r_long_flag <= 1'b0;
                            r_dcnt      <= '0;
                            r_hcnt      <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + c_DONE;
                        end
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                    end
                endcase
            end
        end

        assign bus.btn_level[g]    = r_level;
        assign bus.btn_press[g]    = r_press;
        assign bus.btn_release[g]  = r_release;
        assign bus.btn_long[g]     = r_long;
        assign bus.btn_was_long[g] = r_was_long;
    end

endmodule
`default_nettype wire
